// File: rtl/lanzones_imem_rsp.sv
// lanzones_imem_rsp: the instruction-memory side of the lanzones core fetch port.
//
// The block runs in two phases.
//   Load phase (LEn=0): the word-addressed RAM is written through LWEn/LWAddr/LWData.
//     Fetch requests are ignored. A high LDone, either a pulse or a level, moves the
//     block into the run phase at the next edge.
//   Run phase (LEn=1): the RAM is read-only. Fetches are served through a three-state
//     FSM (IDLE -> WAIT -> RESP). LEn stays high until reset.
//
// Fetch handshake (valid/ready):
//   - The core raises RRdy with a word address on RAddr. In IDLE, an edge that sees
//     LEn & RRdy captures RAddr into areg. This is the request edge N.
//   - RVld rises after edge N+LATENCY. RData becomes valid at the same edge.
//   - RVld and RData hold steady until an edge sees RRdy=1 while in RESP. That edge
//     completes the transfer: RVld drops, RData keeps its last value, and the FSM
//     returns to IDLE. The next request can be captured one edge later, so there is
//     one bubble between transfers.
//   - RVld never falls without a handshake, except on reset.
//   - RAddr is ignored outside IDLE; the response always comes from areg.
//
// Out-of-range addresses: any address with a nonzero bit in [31:AW] returns NOP_WORD.
// It also sets the sticky ErrAddr flag, which only reset clears.
//
// Reset asserts asynchronously and is released on a clock edge. It clears all control
// state, including LEn, but not the RAM contents. A fresh LDone is needed after every
// reset.
module lanzones_imem_rsp #(
  parameter int          AW       = 8,
  parameter int          LATENCY  = 2,             // legal range 1..15
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RRdy,
  input  logic [31:0]   RAddr,
  output logic          RVld,
  output logic [31:0]   RData,
  output logic          LEn,
  input  logic          LWEn,
  input  logic [AW-1:0] LWAddr,
  input  logic [31:0]   LWData,
  input  logic          LDone,
  output logic          ErrAddr
);

  localparam int DEPTH = 2 ** AW;

  // The countdown starts at LATENCY-1. WAIT is always visited at least once, so the
  // response lands exactly LATENCY edges after the capture edge, for any legal LATENCY.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic [31:0] areg;

  // Single-cycle strobes from the FSM into the datapath.
  logic        capture;     // IDLE accepts a request this edge
  logic        enter_resp;  // WAIT finishes this edge; load response data
  logic        handshake;   // RESP completes a transfer this edge
  logic        in_range;    // areg addresses a word that exists in the RAM

  logic [31:0] mem [DEPTH];

  // Address range check: the upper bits must all be zero.
  assign in_range = (areg[31:AW] == '0);

  // Preload write port; the RAM is only writable before the run phase starts.
  always_ff @(posedge clk) begin
    if (LWEn && !LEn) begin
      mem[LWAddr] <= LWData;
    end
  end

  // FSM state and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic and handshake strobes.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    capture    = 1'b0;
    enter_resp = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        if (LEn && RRdy) begin
          capture = 1'b1;
          cnt_n   = CNT_LOAD;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          enter_resp = 1'b1;
          state_n    = RESP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP: begin
        if (RRdy) begin
          handshake = 1'b1;
          state_n   = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Request address capture, held for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      areg <= 32'd0;
    end else if (capture) begin
      areg <= RAddr;
    end
  end

  // Load-complete enable: set by LDone during the load phase, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      LEn <= 1'b0;
    end else if (!LEn && LDone) begin
      LEn <= 1'b1;
    end
  end

  // Response valid: rises when data is loaded, falls only on a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RVld <= 1'b0;
    end else if (enter_resp) begin
      RVld <= 1'b1;
    end else if (handshake) begin
      RVld <= 1'b0;
    end
  end

  // Response data: a RAM word for in-range addresses, NOP_WORD otherwise; held between loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RData <= 32'd0;
    end else if (enter_resp) begin
      if (in_range) begin
        RData <= mem[areg[AW-1:0]];
      end else begin
        RData <= NOP_WORD;
      end
    end
  end

  // Sticky out-of-range flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ErrAddr <= 1'b0;
    end else if (enter_resp && !in_range) begin
      ErrAddr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lanzones_imem_rsp.sv
// Directed bench for lanzones_imem_rsp.
// dut uses LATENCY=2 and dut1 uses LATENCY=1; both share one stimulus stream.
module tb_lanzones_imem_rsp;

  logic        clk = 1'b0;
  logic        rst;
  logic        rrdy;
  logic [31:0] raddr;
  logic        lwen;
  logic [7:0]  lwaddr;
  logic [31:0] lwdata;
  logic        ldone;

  logic        rvld;
  logic [31:0] rdata;
  logic        len;
  logic        erraddr;

  logic        rvld1;
  logic [31:0] rdata1;
  logic        len1;
  logic        erraddr1;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] pre [4];

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  lanzones_imem_rsp #(.AW(8), .LATENCY(2), .NOP_WORD(32'h00000013)) dut (
    .clk(clk), .rst(rst), .RRdy(rrdy), .RAddr(raddr), .RVld(rvld), .RData(rdata),
    .LEn(len), .LWEn(lwen), .LWAddr(lwaddr), .LWData(lwdata), .LDone(ldone),
    .ErrAddr(erraddr)
  );

  lanzones_imem_rsp #(.AW(8), .LATENCY(1), .NOP_WORD(32'h00000013)) dut1 (
    .clk(clk), .rst(rst), .RRdy(rrdy), .RAddr(raddr), .RVld(rvld1), .RData(rdata1),
    .LEn(len1), .LWEn(lwen), .LWAddr(lwaddr), .LWData(lwdata), .LDone(ldone),
    .ErrAddr(erraddr1)
  );

  // Advance one active edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    pre[0] = 32'h00300093;
    pre[1] = 32'h00402103;
    pre[2] = 32'h00000013;
    pre[3] = 32'hDEADBEEF;

    rst = 1'b1; rrdy = 1'b0; raddr = 32'd0;
    lwen = 1'b0; lwaddr = 8'd0; lwdata = 32'd0; ldone = 1'b0;

    // Reset state.
    step();
    step();
    check("rst_rvld", {31'd0, rvld}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_len", {31'd0, len}, 32'd0);
    check("rst_err", {31'd0, erraddr}, 32'd0);
    rst = 1'b0;

    // Preload mem[0..3] while RRdy is held high; no fetch may start.
    rrdy = 1'b1;
    raddr = 32'd1;
    for (int i = 0; i < 4; i++) begin
      lwen = 1'b1;
      lwaddr = 8'(i);
      lwdata = pre[i];
      step();
      check("load_rvld", {31'd0, rvld}, 32'd0);
      check("load_len", {31'd0, len}, 32'd0);
    end
    lwen = 1'b0;
    rrdy = 1'b0;
    ldone = 1'b1;
    step();
    check("ldone_len", {31'd0, len}, 32'd1);
    check("ldone_rvld", {31'd0, rvld}, 32'd0);
    ldone = 1'b0;

    // Run-phase writes and LDone are ignored.
    lwen = 1'b1; lwaddr = 8'd0; lwdata = 32'd0; ldone = 1'b1;

    // LATENCY=2, RAddr=1, RRdy held high: capture N, RVld after N+2, handshake at N+3.
    raddr = 32'd1;
    rrdy = 1'b1;
    step();                                          // N: capture
    check("l2_n_rvld", {31'd0, rvld}, 32'd0);
    step();                                          // N+1
    check("l2_n1_rvld", {31'd0, rvld}, 32'd0);
    step();                                          // N+2
    check("l2_n2_rvld", {31'd0, rvld}, 32'd1);
    check("l2_n2_rdata", rdata, 32'h00402103);
    raddr = 32'd3;
    step();                                          // N+3: handshake
    check("l2_n3_rvld", {31'd0, rvld}, 32'd0);
    check("l2_n3_hold", rdata, 32'h00402103);

    // RAddr=3 captured at the next edge; RAddr changed afterwards; RRdy low for 3 cycles in RESP.
    step();                                          // capture of address 3
    rrdy = 1'b0;
    raddr = 32'd2;
    step();
    step();
    check("stall_rvld0", {31'd0, rvld}, 32'd1);
    check("stall_rdata0", rdata, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_rvld", {31'd0, rvld}, 32'd1);
      check("stall_rdata", rdata, 32'hDEADBEEF);
    end
    rrdy = 1'b1;
    step();                                          // handshake
    check("stall_hs_rvld", {31'd0, rvld}, 32'd0);
    rrdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("one_hs_rvld", {31'd0, rvld}, 32'd0);
    end

    // Out-of-range address returns NOP_WORD and sets the sticky error flag.
    raddr = 32'h00000100;
    rrdy = 1'b1;
    step();
    rrdy = 1'b0;
    raddr = 32'd2;
    step();
    step();
    check("oor_rvld", {31'd0, rvld}, 32'd1);
    check("oor_rdata", rdata, 32'h00000013);
    check("oor_err", {31'd0, erraddr}, 32'd1);
    rrdy = 1'b1;
    raddr = 32'd0;
    step();                                          // handshake
    check("oor_hs_rvld", {31'd0, rvld}, 32'd0);
    step();                                          // capture of address 0
    rrdy = 1'b0;
    step();
    step();
    check("mem0_rvld", {31'd0, rvld}, 32'd1);
    check("mem0_rdata", rdata, 32'h00300093);
    check("err_sticky", {31'd0, erraddr}, 32'd1);
    rrdy = 1'b1;
    step();
    rrdy = 1'b0;
    lwen = 1'b0; ldone = 1'b0;
    check("mem0_hs_rvld", {31'd0, rvld}, 32'd0);

    // Reset asserted mid-WAIT.
    raddr = 32'd1;
    rrdy = 1'b1;
    step();                                          // capture; dut now in WAIT
    rrdy = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rw_rvld", {31'd0, rvld}, 32'd0);
    check("rw_len", {31'd0, len}, 32'd0);
    check("rw_err", {31'd0, erraddr}, 32'd0);
    step();
    rst = 1'b0;
    rrdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rw_noreq_rvld", {31'd0, rvld}, 32'd0);
      check("rw_noreq_len", {31'd0, len}, 32'd0);
    end
    rrdy = 1'b0;
    ldone = 1'b1;
    step();
    ldone = 1'b0;
    check("rw_reload_len", {31'd0, len}, 32'd1);

    // Reset asserted mid-RESP, on an out-of-range response.
    raddr = 32'h00000100;
    rrdy = 1'b1;
    step();
    rrdy = 1'b0;
    step();
    step();
    check("rr_pre_rvld", {31'd0, rvld}, 32'd1);
    check("rr_pre_err", {31'd0, erraddr}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rr_rvld", {31'd0, rvld}, 32'd0);
    check("rr_len", {31'd0, len}, 32'd0);
    check("rr_err", {31'd0, erraddr}, 32'd0);
    check("rr_rdata", rdata, 32'd0);
    step();
    rst = 1'b0;
    ldone = 1'b1;
    step();
    ldone = 1'b0;
    check("rr_reload_len", {31'd0, len}, 32'd1);
    check("rr_reload_len1", {31'd0, len1}, 32'd1);

    // LATENCY=1 build answers after N+1, LATENCY=2 after N+2; RAM content survives reset.
    raddr = 32'd1;
    rrdy = 1'b1;
    step();                                          // N: capture in both
    check("l1_n_rvld1", {31'd0, rvld1}, 32'd0);
    step();                                          // N+1
    check("l1_n1_rvld1", {31'd0, rvld1}, 32'd1);
    check("l1_n1_rdata1", rdata1, 32'h00402103);
    check("l1_n1_rvld", {31'd0, rvld}, 32'd0);
    step();                                          // N+2
    check("l1_n2_rvld1", {31'd0, rvld1}, 32'd0);
    check("l1_n2_rvld", {31'd0, rvld}, 32'd1);
    check("l1_n2_rdata", rdata, 32'h00402103);
    check("l1_err1", {31'd0, erraddr1}, 32'd0);
    rrdy = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
